// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter letting several byte-stream requesters share one UART
// transmitter; a grant lasts until s_last or until MAX_BURST bytes have passed.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 64,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*NUM_REQ-1:0] s_data,
  input  logic [NUM_REQ-1:0]   s_valid,
  input  logic [NUM_REQ-1:0]   s_last,
  output logic [NUM_REQ-1:0]   s_ready,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 msg_done,
  output logic                 forced_rel
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [8:0]     cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           frc_q, frc_d;

  logic           found;
  logic [IDW-1:0] sel;
  logic           xfer, beat, last_beat, burst_end;

  // Rotating priority search: first valid requester at or above rr_q.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    found = 1'b0;
    sel   = rr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && s_valid[(int'(rr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        sel   = IDW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  assign xfer      = (state_q == XFER);
  assign beat      = xfer && s_valid[gid_q] && m_ready;
  assign last_beat = beat && s_last[gid_q];
  assign burst_end = beat && (cnt_q == 9'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    frc_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = sel;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_d = cnt_q + 9'd1;
          if (last_beat || burst_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
            // s_last wins when it coincides with the burst limit.
            frc_d   = !s_last[gid_q];
            rr_d    = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      frc_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      frc_q   <= frc_d;
    end
  end

  // Data path is a pure mux on the held grant; nothing passes while IDLE.
  assign m_data     = s_data[{gid_q, 3'b000} +: 8];
  assign m_valid    = xfer && s_valid[gid_q];
  assign s_ready    = xfer ? (NUM_REQ'(m_ready) << gid_q) : '0;
  assign grant_id   = gid_q;
  assign busy       = xfer;
  assign msg_done   = done_q;
  assign forced_rel = frc_q;

endmodule
